pc_fetch_control: RTL and testbench

- Consumer end of the next-PC select path: registers the next-PC value chosen by the branch/jump muxing and drives the fetch address.
- Owns the program counter, the per-cycle pipeline-advance enable, and debug run/step/halt sequencing.
- Sits between the next-PC mux chain and instruction memory / IF-ID register; the hazard unit and debug unit drive its control inputs.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_fetch_control_sat_counter.sv | 31 +++
 rtl/pc_fetch_control.sv | 92 +++++++++
 tb/tb_pc_fetch_control.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-control state encoding, PC increment and the
// HALT opcode used by both the instruction decoder and the fetch controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  localparam int PC_INC = 4;

  localparam logic [31:0] HALT_OPCODE = 32'hFC00_0000;

  function automatic logic is_halt_opcode(input logic [31:0] instr);
    return instr == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pc_fetch_control_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pc_fetch_control.sv
// Program counter register, pipeline-advance enable and debug run/step/halt
// sequencing at the consumer end of the next-PC select path.
module pc_fetch_control
  import cpu_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter logic [NBITS-1:0] PC_RESET = '0,
  parameter int               CNT_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NBITS-1:0]    i_NextPC,
  input  logic                i_Stall,
  input  logic                i_HaltInstr,
  input  logic                i_DbgRun,
  input  logic                i_DbgStep,
  output logic [NBITS-1:0]    o_PC,
  output logic [NBITS-1:0]    o_PCPlus4,
  output logic                o_PipeEnable,
  output logic                o_FetchValid,
  output logic                o_Halted,
  output logic                o_Misaligned,
  output logic [CNT_BITS-1:0] o_CycleCount
);

  fetch_state_e     state_q;
  logic [NBITS-1:0] pc_q;
  logic             misaligned_q;
  logic             pipe_en;
  logic             advance;
  logic             halt_taken;

  assign pipe_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign advance    = pipe_en & ~i_Stall & ~i_HaltInstr;
  // A HALT seen during a stall is not acted on; it will be refetched.
  assign halt_taken = i_HaltInstr & ~i_Stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      misaligned_q <= 1'b0;
    end else begin
      if (advance) begin
        pc_q <= {i_NextPC[NBITS-1:2], 2'b00};
        if (i_NextPC[1:0] != 2'b00) begin
          misaligned_q <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (i_DbgRun) begin
            state_q <= ST_RUN;
          end else if (i_DbgStep) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (halt_taken) begin
            state_q <= ST_HALTED;
          end
        end
        ST_STEP: begin
          // A stalled step stays here until one real advance happens.
          if (halt_taken) begin
            state_q <= ST_HALTED;
          end else if (!i_Stall) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_BITS)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (pipe_en),
    .o_count (o_CycleCount)
  );

  assign o_PC         = pc_q;
  assign o_PCPlus4    = pc_q + NBITS'(PC_INC);
  assign o_PipeEnable = pipe_en;
  assign o_FetchValid = pipe_en & ~i_HaltInstr;
  assign o_Halted     = (state_q == ST_HALTED);
  assign o_Misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed and randomized checks of pc_fetch_control against a mode-flag
// reference model; uses a 4-bit cycle counter so saturation is reachable.
module tb_pc_fetch_control;

  localparam int NB     = 32;
  localparam int CB     = 4;
  localparam int CNTMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] next_pc;
  logic          stall, halt_in, dbg_run, dbg_step;
  logic [NB-1:0] o_pc, o_pc4;
  logic          o_pipe, o_fv, o_halted, o_mis;
  logic [CB-1:0] o_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model: plain mode flags, PC, sticky flag, integer count.
  bit            m_run, m_step, m_halt, m_mis;
  logic [NB-1:0] m_pc;
  int            m_cnt;

  always #5 clk = ~clk;

  pc_fetch_control #(.NBITS(NB), .PC_RESET('0), .CNT_BITS(CB)) dut (
    .i_clk(clk), .i_reset(rst), .i_NextPC(next_pc), .i_Stall(stall),
    .i_HaltInstr(halt_in), .i_DbgRun(dbg_run), .i_DbgStep(dbg_step),
    .o_PC(o_pc), .o_PCPlus4(o_pc4), .o_PipeEnable(o_pipe),
    .o_FetchValid(o_fv), .o_Halted(o_halted), .o_Misaligned(o_mis),
    .o_CycleCount(o_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ph);
    logic [NB-1:0] exp_pc4;
    bit pipe;
    pipe    = m_run | m_step;
    exp_pc4 = m_pc + 32'd4;
    chk({ph, " pc"},       64'(o_pc),     64'(m_pc));
    chk({ph, " pcplus4"},  64'(o_pc4),    64'(exp_pc4));
    chk({ph, " pipe_en"},  64'(o_pipe),   64'(pipe));
    chk({ph, " fetch_v"},  64'(o_fv),     64'(pipe & ~halt_in));
    chk({ph, " halted"},   64'(o_halted), 64'(m_halt));
    chk({ph, " misalign"}, 64'(o_mis),    64'(m_mis));
    chk({ph, " cyclecnt"}, 64'(o_cnt),    64'(m_cnt));
  endtask

  task automatic model_reset();
    m_run = 0; m_step = 0; m_halt = 0; m_mis = 0; m_pc = '0; m_cnt = 0;
  endtask

  // Starts at posedge+1, ends at the following posedge+1.
  task automatic cycle(input string ph, input logic [NB-1:0] npc,
                       input bit st, input bit hi, input bit dr, input bit ds);
    bit pipe;
    next_pc = npc; stall = st; halt_in = hi; dbg_run = dr; dbg_step = ds;
    #1;
    check_all(ph);
    pipe = m_run | m_step;
    if (pipe && !st && !hi) begin
      m_pc = {npc[NB-1:2], 2'b00};
      if (npc[1:0] != 2'b00) m_mis = 1;
    end
    if (pipe && m_cnt < CNTMAX) m_cnt++;
    if (m_halt) begin
    end else if (m_run) begin
      if (hi && !st) begin m_run = 0; m_halt = 1; end
    end else if (m_step) begin
      if (hi && !st) begin m_step = 0; m_halt = 1; end
      else if (!st) m_step = 0;
    end else begin
      if (dr) m_run = 1;
      else if (ds) m_step = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and checked between clock edges.
  task automatic async_reset(input string ph);
    next_pc = '0; stall = 0; halt_in = 0; dbg_run = 0; dbg_step = 0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(ph);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    next_pc = '0; stall = 0; halt_in = 0; dbg_run = 0; dbg_step = 0;
    model_reset();
    @(posedge clk);
    #1;
    async_reset("init_reset");

    // Sequential run 0,4,8,12
    cycle("run_start", m_pc + 4, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("run_seq", m_pc + 4, 0, 0, 0, 0);
    chk("run_pc12", 64'(o_pc), 64'(32'd12));
    chk("run_cnt3", 64'(o_cnt), 64'(4'd3));

    // Stall holds PC, counter keeps counting
    cycle("stall1", 32'h40, 1, 0, 0, 0);
    cycle("stall2", 32'h40, 1, 0, 0, 0);
    cycle("stall_rel", 32'h40, 0, 0, 0, 0);
    cycle("after_stall", m_pc + 4, 1, 0, 0, 0);

    // Stalled single step retries, then returns to idle
    async_reset("rst_step");
    cycle("step_pulse", 32'h8, 0, 0, 0, 1);
    cycle("step_stalled", 32'h8, 1, 0, 0, 0);
    cycle("step_go", 32'h8, 0, 0, 0, 0);
    cycle("step_idle", 32'h100, 0, 0, 0, 0);
    chk("step_pc8", 64'(o_pc), 64'(32'h8));

    // HALT at 0x20, then debug pulses ignored
    async_reset("rst_halt");
    cycle("halt_run", 32'h20, 0, 0, 1, 0);
    cycle("halt_jump", 32'h20, 0, 0, 0, 0);
    cycle("halt_stalled", 32'h24, 1, 1, 0, 0);
    cycle("halt_take", 32'h24, 0, 1, 0, 0);
    cycle("halt_run_pulse", 32'h30, 0, 0, 1, 0);
    cycle("halt_step_pulse", 32'h30, 0, 0, 0, 1);
    cycle("halt_hold", 32'h30, 0, 0, 0, 0);
    chk("halt_pc20", 64'(o_pc), 64'(32'h20));

    // Misaligned target, sticky flag, async clear
    async_reset("rst_mis");
    cycle("mis_run", 32'h4, 0, 0, 1, 0);
    cycle("mis_jump", 32'h13, 0, 0, 0, 0);
    cycle("mis_next", m_pc + 4, 0, 0, 0, 0);
    cycle("mis_sticky", m_pc + 4, 0, 0, 0, 0);
    chk("mis_set", 64'(o_mis), 64'(1'b1));
    async_reset("mis_async_rst");

    // Run beats step when both arrive; counter saturates
    cycle("both_pulse", m_pc + 4, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle("sat_run", m_pc + 4, 0, 0, 0, 0);
    chk("sat_cnt15", 64'(o_cnt), 64'(4'hF));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [NB-1:0] npc;
      bit st, hi, dr, ds;
      if (($urandom % 60 == 0) || (m_halt && ($urandom % 6 == 0))) begin
        async_reset("rnd_reset");
      end else begin
        npc = ($urandom % 6 == 0) ? NB'($urandom) : m_pc + 4;
        st  = ($urandom % 4 == 0);
        hi  = ($urandom % 25 == 0);
        dr  = ($urandom % 10 == 0);
        ds  = ($urandom % 8 == 0);
        cycle("rnd", npc, st, hi, dr, ds);
      end
    end
    check_all("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
